// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
//   Multi-cycle, byte-addressed data memory with a BUSYWAIT stall handshake.
//   A request seen in IDLE is latched, held in BUSY for LATENCY cycles, then
//   committed. DONE gives the datapath one cycle with BUSYWAIT low so that the
//   PC can advance past the memory instruction.
//
// Ports
//   CLK        in   system clock, all state updates on its rising edge
//   RESET      in   synchronous active-high reset (also clears the array)
//   READ       in   read request from the control unit
//   WRITE      in   write request from the control unit (wins over READ)
//   ADDRESS    in   word address (ALU result)
//   WRITEDATA  in   store data (register file OUT1)
//   READDATA   out  load data, registered, updated only on a read commit
//   BUSYWAIT   out  stall request to the control unit and PC
//   READ_COUNT  out [15:0] saturating read-commit count  (DMEM_STATS_EN only)
//   WRITE_COUNT out [15:0] saturating write-commit count (DMEM_STATS_EN only)
//
// Build option
//   DMEM_STATS_EN  define to add the READ_COUNT / WRITE_COUNT outputs.
//
// State | Meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for READ/WRITE; BUSYWAIT follows the request combinationally
// BUSY  | access in flight; cnt counts down, commit on the edge where cnt==0
// DONE  | one-cycle release with BUSYWAIT low; always returns to IDLE
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
`ifdef DMEM_STATS_EN
  output logic [15:0]       READ_COUNT,
  output logic [15:0]       WRITE_COUNT,
`endif
  output logic              BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_write_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // Combinational in IDLE so the requesting instruction stalls in its own cycle.
  assign BUSYWAIT = !RESET && (((state == IDLE) && (READ || WRITE)) || (state == BUSY));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      READDATA   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
`ifdef DMEM_STATS_EN
      READ_COUNT  <= '0;
      WRITE_COUNT <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (READ || WRITE) begin
            addr_q     <= ADDRESS;
            wdata_q    <= WRITEDATA;
            op_write_q <= WRITE;
            cnt        <= CNT_LOAD;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            if (op_write_q) begin
              mem[addr_q] <= wdata_q;
`ifdef DMEM_STATS_EN
              if (WRITE_COUNT != 16'hFFFF) WRITE_COUNT <= WRITE_COUNT + 16'd1;
`endif
            end else begin
              READDATA <= mem[addr_q];
`ifdef DMEM_STATS_EN
              if (READ_COUNT != 16'hFFFF) READ_COUNT <= READ_COUNT + 16'd1;
`endif
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // Request lines are still held by the finishing instruction; ignore them.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

  localparam int LATENCY = 5;

  logic       CLK;
  logic       RESET;
  logic       READ;
  logic       WRITE;
  logic [7:0] ADDRESS;
  logic [7:0] WRITEDATA;
  logic [7:0] READDATA;
  logic       BUSYWAIT;
`ifdef DMEM_STATS_EN
  logic [15:0] READ_COUNT;
  logic [15:0] WRITE_COUNT;
`endif

  data_memory_ctrl #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(256), .LATENCY(LATENCY)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .READ(READ),
    .WRITE(WRITE),
    .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA),
    .READDATA(READDATA),
`ifdef DMEM_STATS_EN
    .READ_COUNT(READ_COUNT),
    .WRITE_COUNT(WRITE_COUNT),
`endif
    .BUSYWAIT(BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit       is_read;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_model [256];
  logic [7:0] last_rd;
  int         tests;
  int         fails;
`ifdef DMEM_STATS_EN
  int         exp_rc;
  int         exp_wc;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
    last_rd = 8'h00;
`ifdef DMEM_STATS_EN
    exp_rc = 0;
    exp_wc = 0;
`endif
  endtask

  // Monitor: a completed access is a falling BUSYWAIT outside reset.
  initial begin : monitor
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        run = 0;
      end else if (BUSYWAIT) begin
        run++;
      end else if (run > 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'(run), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stall_cycles", 32'(run), 32'(LATENCY + 1));
          check(e.is_read ? "read_data" : "readdata_hold_on_write", 32'(READDATA), 32'(e.data));
        end
        run = 0;
      end
    end
  end

  // Called and returns at posedge+1. Holds the request until BUSYWAIT is seen low.
  task automatic do_access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    int   n;
    e.addr = a;
    if (wr) begin
      mem_model[a] = d;
      e.is_read = 1'b0;
      e.data = last_rd;
`ifdef DMEM_STATS_EN
      if (exp_wc < 65535) exp_wc++;
`endif
    end else begin
      e.is_read = 1'b1;
      e.data = mem_model[a];
      last_rd = mem_model[a];
`ifdef DMEM_STATS_EN
      if (exp_rc < 65535) exp_rc++;
`endif
    end
    exp_q.push_back(e);
    READ = rd;
    WRITE = wr;
    ADDRESS = a;
    WRITEDATA = d;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (BUSYWAIT && n < 50);
    if (n >= 50) check("busywait_timeout", 32'(n), 32'd0);
    @(posedge CLK);
    #1;
    READ = 1'b0;
    WRITE = 1'b0;
    ADDRESS = 8'($urandom);
    WRITEDATA = 8'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit         rd, wr;
    int         sel;
    logic [7:0] a, d;
    tests = 0;
    fails = 0;
    model_reset();
    READ = 1'b1;
    WRITE = 1'b0;
    ADDRESS = 8'h10;
    WRITEDATA = 8'h00;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("busywait_forced_in_reset", 32'(BUSYWAIT), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    READ = 1'b0;
    @(negedge CLK);
    check("reset_readdata", 32'(READDATA), 32'h00);
    check("reset_busywait", 32'(BUSYWAIT), 32'd0);
    @(posedge CLK);
    #1;

    do_access(1, 0, 8'h10, 8'h00);
    idle_cycles(1);
    do_access(0, 1, 8'h2A, 8'h5C);
    idle_cycles(2);
    do_access(1, 0, 8'h2A, 8'h00);
    idle_cycles(1);
    // READ and WRITE together: write wins, READDATA stays at 0x5C.
    do_access(1, 1, 8'h03, 8'h77);
    do_access(1, 0, 8'h03, 8'h00);
    // Back-to-back write then read of the same word.
    do_access(0, 1, 8'h01, 8'h11);
    do_access(1, 0, 8'h01, 8'h00);
    do_access(0, 1, 8'h00, 8'hC3);
    do_access(1, 0, 8'h00, 8'h00);

    // Reset two cycles into BUSY aborts a write to 0xFF.
    do_access(0, 1, 8'hFF, 8'h3C);
    READ = 1'b0;
    WRITE = 1'b1;
    ADDRESS = 8'hFF;
    WRITEDATA = 8'hA5;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    WRITE = 1'b0;
    @(negedge CLK);
    check("busywait_during_abort_reset", 32'(BUSYWAIT), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    @(negedge CLK);
    check("post_abort_busywait", 32'(BUSYWAIT), 32'd0);
    check("post_abort_readdata", 32'(READDATA), 32'h00);
    @(posedge CLK);
    #1;
    do_access(1, 0, 8'hFF, 8'h00);
    do_access(1, 0, 8'h2A, 8'h00);

    for (int k = 0; k < 60; k++) begin
      sel = int'($urandom_range(0, 99));
      rd = (sel < 40) || (sel >= 85);
      wr = (sel >= 40);
      a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      d = 8'($urandom);
      do_access(rd, wr, a, d);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    idle_cycles(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef DMEM_STATS_EN
    check("read_count", 32'(READ_COUNT), 32'(exp_rc));
    check("write_count", 32'(WRITE_COUNT), 32'(exp_wc));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
